busctrl_n: RTL and testbench

Parametrised successor to the fixed ECO32 bus controller. It connects the CPU bus master to `NSLV` slave ports through a parameter-defined address map. Each access runs through a registered handshake FSM with a per-access timeout and a write-protect check. Decode misses, timeouts and protected writes complete the CPU cycle with zero data and latch a sticky error that can drive a CPU interrupt line.

---
 rtl/busctrl_pkg.sv | 25 ++
 rtl/busctrl_n_addr_decode.sv | 33 +++
 rtl/busctrl_n.sv | 197 +++++++++++++++++++
 tb/tb_busctrl_n.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/busctrl_pkg.sv
// busctrl_pkg
// Shared types and constants for the parametrised bus controller.
//   state_t     : handshake FSM states
//   ERR_*       : error cause encodings reported on err_cause
//   idx_width() : width of a slave index for a given slave count
package busctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10,
        ERR    = 2'b11
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DECODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_WRPROT  = 2'b11;

    // A single slave still needs a 1-bit index so the select register exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/busctrl_n_addr_decode.sv
// addr_decode
// Combinational priority address decoder for the bus controller.
//   addr : byte address to decode
//   hit  : 1 when at least one window matches
//   idx  : index of the lowest-numbered matching window (0 when no hit)
module addr_decode
    import busctrl_pkg::*;
#(
    parameter int                   NSLV     = 8,
    parameter logic [NSLV*32-1:0]   SLV_BASE = '0,
    parameter logic [NSLV*32-1:0]   SLV_MASK = '1,
    parameter int                   IDX_W    = idx_width(NSLV)
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Walk from the highest index down so the lowest matching window is
    // the last one written and therefore wins on overlap.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[32*i +: 32]) ==
                (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/busctrl_n.sv
// busctrl_n
// Bus controller between one CPU master and NSLV slave ports. Each CPU
// request is decoded through a parameter-defined address map and run
// through a registered handshake with a per-access timeout and a
// write-protect check. Failed accesses finish the CPU cycle with zero data
// and record a sticky error.
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   cpu_en/wr/size/addr    : CPU request (held until cpu_wt drops)
//   cpu_data_out           : CPU write data
//   cpu_data_in, cpu_wt    : read data / wait (0 for one cycle per access)
//   slv_en                 : one-hot slave enable
//   slv_wr/size/addr       : latched request towards the slaves
//   slv_data_in            : latched write data towards the slaves
//   slv_data_out, slv_wt   : packed slave read data / per-slave wait
//   err_irq/addr/cause     : sticky error record, cleared by err_ack
//
// state  | meaning
// IDLE   | waiting for cpu_en; latches request and decodes it
// ACCESS | selected slave enabled, counting cycles towards timeout
// DONE   | one-cycle completion, captured read data on cpu_data_in
// ERR    | one-cycle completion with zero data after miss/timeout/protect
module busctrl_n
    import busctrl_pkg::*;
#(
    parameter int                   NSLV     = 8,
    parameter logic [NSLV*32-1:0]   SLV_BASE = '0,
    parameter logic [NSLV*32-1:0]   SLV_MASK = '1,
    parameter logic [NSLV-1:0]      SLV_RO   = '0,
    parameter int                   TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_en,
    input  logic               cpu_wr,
    input  logic [1:0]         cpu_size,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_data_out,
    output logic [31:0]        cpu_data_in,
    output logic               cpu_wt,
    output logic [NSLV-1:0]    slv_en,
    output logic               slv_wr,
    output logic [1:0]         slv_size,
    output logic [31:0]        slv_addr,
    output logic [31:0]        slv_data_in,
    input  logic [NSLV*32-1:0] slv_data_out,
    input  logic [NSLV-1:0]    slv_wt,
    output logic               err_irq,
    output logic [31:0]        err_addr,
    output logic [1:0]         err_cause,
    input  logic               err_ack
);

    localparam int         IDX_W    = idx_width(NSLV);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;

    addr_decode #(
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .IDX_W    (IDX_W)
    ) u_addr_decode (
        .addr (cpu_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    state_t           state, state_nxt;
    logic [IDX_W-1:0] sel, sel_nxt;
    logic [15:0]      cnt, cnt_nxt;
    logic [1:0]       cause_nxt;
    logic [31:0]      fault_addr;
    logic             latch_req;
    logic             ro_hit;
    logic [31:0]      rd_sel;
    logic             wt_sel;
    logic [NSLV-1:0]  en_nxt;

    // Per-index lookups done by comparison so a non-power-of-two NSLV never
    // indexes past the end of the packed vectors.
    always_comb begin
        ro_hit = 1'b0;
        rd_sel = '0;
        wt_sel = 1'b1;
        for (int i = 0; i < NSLV; i++) begin
            if (dec_idx == IDX_W'(i)) begin
                ro_hit = SLV_RO[i];
            end
            if (sel == IDX_W'(i)) begin
                rd_sel = slv_data_out[32*i +: 32];
                wt_sel = slv_wt[i];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        cnt_nxt    = cnt;
        cause_nxt  = ERR_NONE;
        fault_addr = slv_addr;
        latch_req  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_en) begin
                    latch_req  = 1'b1;
                    sel_nxt    = dec_idx;
                    fault_addr = cpu_addr;
                    if (!dec_hit) begin
                        state_nxt = ERR;
                        cause_nxt = ERR_DECODE;
                    end else if (cpu_wr && ro_hit) begin
                        state_nxt = ERR;
                        cause_nxt = ERR_WRPROT;
                    end else begin
                        state_nxt = ACCESS;
                        cnt_nxt   = '0;
                    end
                end
            end
            ACCESS: begin
                cnt_nxt = cnt + 16'd1;
                // Slave completion wins over a timeout in the same cycle.
                if (!wt_sel) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ERR;
                    cause_nxt = ERR_TIMEOUT;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        en_nxt = '0;
        for (int i = 0; i < NSLV; i++) begin
            en_nxt[i] = (state_nxt == ACCESS) && (sel_nxt == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            cnt         <= '0;
            slv_en      <= '0;
            cpu_wt      <= 1'b1;
            cpu_data_in <= '0;
            slv_wr      <= 1'b0;
            slv_size    <= '0;
            slv_addr    <= '0;
            slv_data_in <= '0;
            err_irq     <= 1'b0;
            err_addr    <= '0;
            err_cause   <= ERR_NONE;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            cnt    <= cnt_nxt;
            slv_en <= en_nxt;
            cpu_wt <= !((state_nxt == DONE) || (state_nxt == ERR));

            if (latch_req) begin
                slv_wr      <= cpu_wr;
                slv_size    <= cpu_size;
                slv_addr    <= cpu_addr;
                slv_data_in <= cpu_data_out;
            end

            // DONE is only reached from ACCESS, so slv_wr is already valid.
            if (state_nxt == DONE) begin
                cpu_data_in <= slv_wr ? 32'd0 : rd_sel;
            end else begin
                cpu_data_in <= '0;
            end

            // A new error overrides an acknowledge arriving on the same edge.
            if ((state_nxt == ERR) && (!err_irq || err_ack)) begin
                err_irq   <= 1'b1;
                err_addr  <= fault_addr;
                err_cause <= cause_nxt;
            end else if (err_ack) begin
                err_irq   <= 1'b0;
                err_addr  <= '0;
                err_cause <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_busctrl_n.sv
// tb_busctrl_n
// Self-checking bench for busctrl_n with a four-slave map and TIMEOUT=4.
//   slave0 0x0xxxxxxx, slave1 0x3xxxxxxx, slave2 0x2/0x3xxxxxxx (shadowed
//   by slave1 on 0x3...), slave3 0x8..0xBxxxxxxx read-only; rest unmapped.
// The bench plays the slave side: each access answers after a chosen
// number of wait cycles.
module tb_busctrl_n;

    localparam int NSLV = 4;
    localparam int TO   = 4;

    localparam logic [NSLV*32-1:0] P_BASE = {32'h8000_0000, 32'h2000_0000,
                                             32'h3000_0000, 32'h0000_0000};
    localparam logic [NSLV*32-1:0] P_MASK = {32'hC000_0000, 32'hE000_0000,
                                             32'hF000_0000, 32'hF000_0000};
    localparam logic [NSLV-1:0]    P_RO   = 4'b1000;

    // Reference map, kept as plain per-window arrays.
    localparam logic [31:0] WIN_BASE [NSLV] = '{32'h0000_0000, 32'h3000_0000,
                                                32'h2000_0000, 32'h8000_0000};
    localparam logic [31:0] WIN_MASK [NSLV] = '{32'hF000_0000, 32'hF000_0000,
                                                32'hE000_0000, 32'hC000_0000};
    localparam bit          WIN_RO   [NSLV] = '{1'b0, 1'b0, 1'b0, 1'b1};

    logic               clk = 1'b0;
    logic               reset;
    logic               cpu_en;
    logic               cpu_wr;
    logic [1:0]         cpu_size;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_data_out;
    logic [31:0]        cpu_data_in;
    logic               cpu_wt;
    logic [NSLV-1:0]    slv_en;
    logic               slv_wr;
    logic [1:0]         slv_size;
    logic [31:0]        slv_addr;
    logic [31:0]        slv_data_in;
    logic [NSLV*32-1:0] slv_data_out;
    logic [NSLV-1:0]    slv_wt;
    logic               err_irq;
    logic [31:0]        err_addr;
    logic [1:0]         err_cause;
    logic               err_ack;

    logic [31:0] rdata [NSLV];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NSLV; i++) slv_data_out[32*i +: 32] = rdata[i];
    end

    busctrl_n #(
        .NSLV     (NSLV),
        .SLV_BASE (P_BASE),
        .SLV_MASK (P_MASK),
        .SLV_RO   (P_RO),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_en       (cpu_en),
        .cpu_wr       (cpu_wr),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_in  (cpu_data_in),
        .cpu_wt       (cpu_wt),
        .slv_en       (slv_en),
        .slv_wr       (slv_wr),
        .slv_size     (slv_size),
        .slv_addr     (slv_addr),
        .slv_data_in  (slv_data_in),
        .slv_data_out (slv_data_out),
        .slv_wt       (slv_wt),
        .err_irq      (err_irq),
        .err_addr     (err_addr),
        .err_cause    (err_cause),
        .err_ack      (err_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference error record.
    logic        m_irq;
    logic [31:0] m_addr;
    logic [1:0]  m_cause;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NSLV; i++) begin
            if ((a & WIN_MASK[i]) == WIN_BASE[i]) return i;
        end
        return -1;
    endfunction

    task automatic rand_rdata();
        for (int i = 0; i < NSLV; i++) rdata[i] = $urandom;
    endtask

    task automatic check_err_regs(input string tag);
        check_val({tag, "_irq"},   32'(err_irq),   32'(m_irq));
        check_val({tag, "_addr"},  err_addr,       m_addr);
        check_val({tag, "_cause"}, 32'(err_cause), 32'(m_cause));
    endtask

    // One CPU access. d = wait cycles the slave inserts before answering;
    // ack = err_ack pulsed together with the request edge.
    task automatic run_txn(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int d, input logic ack);
        int               idx;
        int               exp_lat;
        int               exp_en;
        logic [31:0]      exp_data;
        logic             exp_err;
        logic [1:0]       cause;
        logic [NSLV-1:0]  exp_oh;
        int               n;
        int               en_cnt;
        logic [NSLV-1:0]  en_seen;
        logic [31:0]      got_data;
        bit               done;

        idx      = ref_decode(addr);
        exp_oh   = '0;
        exp_err  = 1'b0;
        cause    = 2'b00;
        exp_data = 32'd0;
        if (idx < 0) begin
            exp_lat = 1; exp_en = 0; exp_err = 1'b1; cause = 2'b01;
        end else if (wr && WIN_RO[idx]) begin
            exp_lat = 1; exp_en = 0; exp_err = 1'b1; cause = 2'b11;
        end else begin
            exp_oh[idx] = 1'b1;
            if (d < TO) begin
                exp_lat  = d + 2;
                exp_en   = d + 1;
                exp_data = wr ? 32'd0 : rdata[idx];
            end else begin
                exp_lat = TO + 1;
                exp_en  = TO;
                exp_err = 1'b1;
                cause   = 2'b10;
            end
        end
        if (ack) begin
            m_irq = 1'b0; m_addr = 32'd0; m_cause = 2'b00;
        end
        if (exp_err && !m_irq) begin
            m_irq = 1'b1; m_addr = addr; m_cause = cause;
        end

        @(negedge clk);
        cpu_en       = 1'b1;
        cpu_wr       = wr;
        cpu_size     = size;
        cpu_addr     = addr;
        cpu_data_out = wdata;
        err_ack      = ack;
        slv_wt       = '1;

        n = 0; en_cnt = 0; en_seen = '0; got_data = 32'd0; done = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            err_ack = 1'b0;
            if (slv_en != '0) begin
                en_cnt++;
                en_seen = en_seen | slv_en;
                slv_wt  = (en_cnt == d + 1) ? '0 : '1;
            end else begin
                slv_wt = '1;
            end
            if (cpu_wt == 1'b0) begin
                done     = 1'b1;
                got_data = cpu_data_in;
            end
        end
        cpu_en = 1'b0;
        slv_wt = '1;
        check_val("txn_completes", 32'(done), 32'd1);
        check_val("latency",  32'(n),       32'(exp_lat));
        check_val("en_cycles", 32'(en_cnt), 32'(exp_en));
        check_val("en_onehot", 32'(en_seen), 32'(exp_oh));
        check_val("rd_data",  got_data,     exp_data);
        check_val("slv_addr", slv_addr,     addr);
        check_val("slv_wr",   32'(slv_wr),  32'(wr));
        check_val("slv_size", 32'(slv_size), 32'(size));
        check_val("slv_wdata", slv_data_in, wdata);
        check_err_regs("err");

        @(posedge clk);
        #1;
        check_val("wt_one_cycle", 32'(cpu_wt), 32'd1);
        check_val("en_after", 32'(slv_en), 32'd0);
    endtask

    task automatic idle_ack();
        @(negedge clk);
        err_ack = 1'b1;
        @(posedge clk);
        #1;
        err_ack = 1'b0;
        m_irq = 1'b0; m_addr = 32'd0; m_cause = 2'b00;
        check_err_regs("ack");
    endtask

    initial begin
        logic [31:0] a;
        reset        = 1'b1;
        cpu_en       = 1'b0;
        cpu_wr       = 1'b0;
        cpu_size     = 2'b00;
        cpu_addr     = 32'd0;
        cpu_data_out = 32'd0;
        slv_wt       = '1;
        err_ack      = 1'b0;
        m_irq        = 1'b0;
        m_addr       = 32'd0;
        m_cause      = 2'b00;
        rand_rdata();

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_wt",    32'(cpu_wt),      32'd1);
        check_val("rst_en",    32'(slv_en),      32'd0);
        check_val("rst_data",  cpu_data_in,      32'd0);
        check_val("rst_addr",  slv_addr,         32'd0);
        check_val("rst_wdata", slv_data_in,      32'd0);
        check_val("rst_wr",    32'(slv_wr),      32'd0);
        check_val("rst_size",  32'(slv_size),    32'd0);
        check_err_regs("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_wt", 32'(cpu_wt), 32'd1);

        // Minimum-latency read.
        rand_rdata();
        rdata[0] = 32'hDEAD_BEEF;
        run_txn(1'b0, 2'b10, 32'h0000_0010, 32'd0, 0, 1'b0);
        // Overlap: slave1 wins over slave2.
        rand_rdata();
        run_txn(1'b0, 2'b10, 32'h3000_0000, 32'd0, 1, 1'b0);
        // Unmapped read.
        run_txn(1'b0, 2'b00, 32'hF000_0000, 32'd0, 0, 1'b0);
        idle_ack();
        // Timeout, then a slave answering in its last allowed cycle.
        run_txn(1'b0, 2'b10, 32'h0000_0020, 32'd0, 10, 1'b0);
        idle_ack();
        rand_rdata();
        run_txn(1'b0, 2'b10, 32'h0000_0024, 32'd0, TO - 1, 1'b0);
        // Write-protect, second error retained-first, ack with third error.
        run_txn(1'b1, 2'b10, 32'h8000_0004, 32'h1234_5678, 0, 1'b0);
        run_txn(1'b1, 2'b10, 32'h5000_0000, 32'h0000_0001, 0, 1'b0);
        run_txn(1'b0, 2'b01, 32'hC000_0008, 32'd0, 0, 1'b1);
        // Ack with a clean access clears the record.
        rand_rdata();
        run_txn(1'b1, 2'b10, 32'h2000_0100, 32'hCAFE_F00D, 2, 1'b1);

        for (int t = 0; t < 150; t++) begin
            rand_rdata();
            a = {4'($urandom_range(0, 15)), 28'($urandom)};
            run_txn(1'($urandom), 2'($urandom), a, $urandom,
                    int'($urandom_range(0, TO + 1)), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset in the middle of an access with an error pending.
        run_txn(1'b0, 2'b00, 32'h4000_0000, 32'd0, 0, 1'b0);
        @(negedge clk);
        cpu_en   = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = 32'h0000_0100;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_val("pre_rst_en", 32'(slv_en), 32'h1);
        @(negedge clk);
        reset  = 1'b1;
        cpu_en = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_en",  32'(slv_en),  32'd0);
        check_val("midrst_wt",  32'(cpu_wt),  32'd1);
        check_val("midrst_irq", 32'(err_irq), 32'd0);
        check_val("midrst_addr", slv_addr,    32'd0);
        m_irq = 1'b0; m_addr = 32'd0; m_cause = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        rand_rdata();
        run_txn(1'b0, 2'b10, 32'h0000_0200, 32'd0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
